// File: rtl/hmac_msg_packer.sv
// Message front-end for the HMAC/SHA-3 path: splits wide input beats into
// 32-bit words and groups them into rate-sized blocks for the keccak core.
module hmac_msg_packer #(
    parameter int unsigned IN_W       = 64,
    parameter int unsigned RATE_WORDS = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [$clog2(IN_W/32):0] in_nwords,
    output logic                     in_ready,
    input  logic                     abort,
    output logic                     sha_start_block,
    output logic [31:0]              sha_block_word,
    output logic                     sha_block_word_valid,
    output logic                     sha_block_last,
    output logic [5:0]               sha_words_in_block,
    input  logic                     sha_busy,
    input  logic                     sha_buffer_full,
    output logic [15:0]              msg_blocks,
    output logic                     done
);

    localparam int unsigned NW  = IN_W / 32;
    localparam int unsigned NWW = $clog2(NW) + 1;
    localparam int unsigned CW  = 6;
    localparam int unsigned MBW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT_BLK,
        S_WAIT_FIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IN_W-1:0]    hold_q, hold_d;
    logic [NWW-1:0]     hold_nw_q, hold_nw_d;
    logic               hold_last_q, hold_last_d;
    logic               hold_vld_q, hold_vld_d;
    logic [NWW-1:0]     widx_q, widx_d;
    logic [CW-1:0]      bcnt_q, bcnt_d;
    logic [MBW-1:0]     blocks_q, blocks_d;
    logic               init_q;

    logic               start_q, start_d;
    logic [31:0]        word_q, word_d;
    logic               wvld_q, wvld_d;
    logic               last_q, last_d;
    logic [CW-1:0]      wib_q, wib_d;
    logic               done_q, done_d;

    logic               acc;
    logic               hold_tail;
    logic               take_state;
    logic               xfer;
    logic [31:0]        sel_word;

    // Handshake: hold may refill as soon as its last word is consumed, except
    // after the message's final word (the next message waits for DONE)
    assign acc        = wvld_q && !sha_buffer_full;
    assign hold_tail  = hold_vld_q && ((widx_q + NWW'(1)) == hold_nw_q);
    assign take_state = (state_q == S_IDLE) || (state_q == S_START) || (state_q == S_STREAM);
    assign in_ready   = init_q && take_state &&
                        (!hold_vld_q || (acc && hold_tail && !hold_last_q));
    assign xfer       = in_valid && in_ready;

    // Next state, holding register and next values of the registered outputs
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_nw_d   = hold_nw_q;
        hold_last_d = hold_last_q;
        hold_vld_d  = hold_vld_q;
        widx_d      = widx_q;
        bcnt_d      = bcnt_q;
        blocks_d    = blocks_q;
        sel_word    = '0;
        start_d     = 1'b0;
        word_d      = '0;
        wvld_d      = 1'b0;
        last_d      = 1'b0;
        wib_d       = '0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    blocks_d = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                bcnt_d = '0;
                if (blocks_q != 16'hFFFF) blocks_d = blocks_q + 16'd1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (hold_vld_q && hold_last_q && (hold_nw_q == '0)) begin
                    // empty-last marker is shown for exactly one cycle
                    hold_vld_d = 1'b0;
                    state_d    = S_WAIT_FIN;
                end else if (acc) begin
                    bcnt_d = bcnt_q + CW'(1);
                    widx_d = widx_q + NWW'(1);
                    if (hold_tail) hold_vld_d = 1'b0;
                    if (hold_tail && hold_last_q) begin
                        state_d = S_WAIT_FIN;
                    end else if ((bcnt_q + CW'(1)) == CW'(RATE_WORDS)) begin
                        state_d = S_WAIT_BLK;
                    end
                end
            end
            S_WAIT_BLK: begin
                if (!sha_busy && !sha_buffer_full) state_d = S_START;
            end
            S_WAIT_FIN: begin
                if (!sha_busy) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (xfer) begin
            hold_d      = in_data;
            hold_nw_d   = in_nwords;
            hold_last_d = in_last;
            hold_vld_d  = 1'b1;
            widx_d      = '0;
        end

        if (abort) begin
            state_d    = S_IDLE;
            hold_vld_d = 1'b0;
            widx_d     = '0;
        end

        for (int unsigned k = 0; k < NW; k++) begin
            if (widx_d == NWW'(k)) sel_word = hold_d[32*k +: 32];
        end

        start_d = (state_d == S_START);
        done_d  = (state_d == S_DONE);
        if ((state_d == S_STREAM) && hold_vld_d) begin
            if (widx_d < hold_nw_d) begin
                wvld_d = 1'b1;
                word_d = sel_word;
                last_d = hold_last_d && ((widx_d + NWW'(1)) == hold_nw_d);
                wib_d  = bcnt_d + CW'(1);
            end else if (hold_last_d) begin
                last_d = 1'b1;
                wib_d  = bcnt_d;
            end
        end
    end

    // State, holding register and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_nw_q   <= '0;
            hold_last_q <= 1'b0;
            hold_vld_q  <= 1'b0;
            widx_q      <= '0;
            bcnt_q      <= '0;
            blocks_q    <= '0;
            init_q      <= 1'b0;
            start_q     <= 1'b0;
            word_q      <= '0;
            wvld_q      <= 1'b0;
            last_q      <= 1'b0;
            wib_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_nw_q   <= hold_nw_d;
            hold_last_q <= hold_last_d;
            hold_vld_q  <= hold_vld_d;
            widx_q      <= widx_d;
            bcnt_q      <= bcnt_d;
            blocks_q    <= blocks_d;
            init_q      <= 1'b1;
            start_q     <= start_d;
            word_q      <= word_d;
            wvld_q      <= wvld_d;
            last_q      <= last_d;
            wib_q       <= wib_d;
            done_q      <= done_d;
        end
    end

    assign sha_start_block      = start_q;
    assign sha_block_word       = word_q;
    assign sha_block_word_valid = wvld_q;
    assign sha_block_last       = last_q;
    assign sha_words_in_block   = wib_q;
    assign msg_blocks           = blocks_q;
    assign done                 = done_q;

endmodule
